// File: rtl/guess_entry_buffer.sv
// guess_entry_buffer: collects stabilized symbol keystrokes into an N-digit
// guess, presents the completed guess to the comparator over a valid/ready
// handshake, counts accepted guesses and locks out after MAX_ATTEMPTS.
//
// Optional feature macro: ENTRY_CONFIRM_EN
//   undefined - the key that fills the last digit submits the guess
//   defined   - a full buffer waits for key_enter before it is submitted
//
// Ports:
//   CLOCK_50     in   system clock
//   reset        in   synchronous, active-high reset
//   key_valid    in   one-cycle pulse, key_sym holds a pressed symbol
//   key_sym      in   symbol value (SYM_W bits)
//   key_del      in   one-cycle pulse, backspace
//   key_enter    in   one-cycle pulse, submit (confirm build only)
//   new_game     in   one-cycle pulse, clear guess and attempts
//   guess_ready  in   comparator accepts the presented guess
//   guess_out    out  digit i at [i*SYM_W +: SYM_W], digit 0 entered first
//   guess_valid  out  completed guess presented
//   digit_count  out  digits currently entered
//   attempts     out  guesses accepted by the comparator (saturating)
//   locked       out  attempt limit reached
module guess_entry_buffer #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SYM_W        = 2,
   parameter int unsigned MAX_ATTEMPTS = 10,
   parameter int unsigned ATT_W        = 4,
   parameter int unsigned CNT_W        = $clog2(NUM_DIGITS + 1)
) (
   input  logic                        CLOCK_50,
   input  logic                        reset,
   input  logic                        key_valid,
   input  logic [SYM_W-1:0]            key_sym,
   input  logic                        key_del,
   input  logic                        key_enter,
   input  logic                        new_game,
   input  logic                        guess_ready,
   output logic [NUM_DIGITS*SYM_W-1:0] guess_out,
   output logic                        guess_valid,
   output logic [CNT_W-1:0]            digit_count,
   output logic [ATT_W-1:0]            attempts,
   output logic                        locked
);

   localparam int unsigned GUESS_W = NUM_DIGITS * SYM_W;
   localparam logic [CNT_W-1:0] FULL    = CNT_W'(NUM_DIGITS);
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_DIGITS - 1);
   localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_ATTEMPTS);

   typedef enum logic [1:0] {
      ENTRY   = 2'd0,
      PRESENT = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [GUESS_W-1:0] guess_q, guess_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [ATT_W-1:0]   att_q, att_d;
   logic               valid_q, locked_q;

`ifndef ENTRY_CONFIRM_EN
   // Auto-submit build has no use for the enter key.
   logic key_enter_unused;
   assign key_enter_unused = key_enter;
`endif

   // State and output registers; valid/locked mirror the next state so they
   // are registered, not decoded from state combinationally.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q  <= ENTRY;
         guess_q  <= '0;
         count_q  <= '0;
         att_q    <= '0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         guess_q  <= guess_d;
         count_q  <= count_d;
         att_q    <= att_d;
         valid_q  <= (state_d == PRESENT);
         locked_q <= (state_d == LOCKED);
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      guess_d = guess_q;
      count_d = count_q;
      att_d   = att_q;

      if (new_game) begin
         state_d = ENTRY;
         guess_d = '0;
         count_d = '0;
         att_d   = '0;
      end else begin
         case (state_q)
            ENTRY: begin
               if (key_del) begin
                  // Backspace wins over a simultaneous symbol key.
                  if (count_q != '0) begin
                     for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                        if (CNT_W'(i + 1) == count_q) begin
                           guess_d[i*SYM_W +: SYM_W] = '0;
                        end
                     end
                     count_d = count_q - CNT_W'(1);
                  end
               end else if (key_valid && (count_q < FULL)) begin
                  for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                     if (CNT_W'(i) == count_q) begin
                        guess_d[i*SYM_W +: SYM_W] = key_sym;
                     end
                  end
                  count_d = count_q + CNT_W'(1);
`ifndef ENTRY_CONFIRM_EN
                  if (count_q == LAST) begin
                     state_d = PRESENT;
                  end
`endif
               end
`ifdef ENTRY_CONFIRM_EN
               else if (key_enter && (count_q == FULL)) begin
                  state_d = PRESENT;
               end
`endif
            end

            PRESENT: begin
               if (guess_ready) begin
                  att_d   = (att_q == ATT_MAX) ? att_q : att_q + ATT_W'(1);
                  guess_d = '0;
                  count_d = '0;
                  state_d = (att_d == ATT_MAX) ? LOCKED : ENTRY;
               end
            end

            LOCKED: begin
               guess_d = '0;
            end

            default: begin
               state_d = ENTRY;
            end
         endcase
      end
   end

   assign guess_out   = guess_q;
   assign guess_valid = valid_q;
   assign digit_count = count_q;
   assign attempts    = att_q;
   assign locked      = locked_q;

endmodule

// File: tb/tb_guess_entry_buffer.sv
// Directed bench for guess_entry_buffer at default parameters. Inputs change
// 1 ns after a rising edge; outputs are sampled at the same point, i.e. they
// reflect the edge just taken. Works for both builds of ENTRY_CONFIRM_EN.
module tb_guess_entry_buffer;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       key_valid;
   logic [1:0] key_sym;
   logic       key_del;
   logic       key_enter;
   logic       new_game;
   logic       guess_ready;
   logic [7:0] guess_out;
   logic       guess_valid;
   logic [2:0] digit_count;
   logic [3:0] attempts;
   logic       locked;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef ENTRY_CONFIRM_EN
   localparam logic CONFIRM = 1'b1;
`else
   localparam logic CONFIRM = 1'b0;
`endif

   guess_entry_buffer dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .key_valid   (key_valid),
      .key_sym     (key_sym),
      .key_del     (key_del),
      .key_enter   (key_enter),
      .new_game    (new_game),
      .guess_ready (guess_ready),
      .guess_out   (guess_out),
      .guess_valid (guess_valid),
      .digit_count (digit_count),
      .attempts    (attempts),
      .locked      (locked)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic idle();
      key_valid = 1'b0; key_del = 1'b0; key_enter = 1'b0;
      new_game = 1'b0; guess_ready = 1'b0; reset = 1'b0;
   endtask

   task automatic press(input logic [1:0] s);
      key_valid = 1'b1; key_sym = s;
      step();
      key_valid = 1'b0;
   endtask

   task automatic del();
      key_del = 1'b1;
      step();
      key_del = 1'b0;
   endtask

   // Confirm build only: submit a full buffer with key_enter.
   task automatic confirm();
      if (CONFIRM) begin
         key_enter = 1'b1;
         step();
         key_enter = 1'b0;
      end
   endtask

   task automatic accept();
      guess_ready = 1'b1;
      step();
      guess_ready = 1'b0;
   endtask

   initial begin
      idle();
      key_sym = 2'd0;

      // Reset state
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_guess", 32'(guess_out), 32'h00);
      check("rst_count", 32'(digit_count), 32'd0);
      check("rst_att", 32'(attempts), 32'd0);
      check("rst_valid", 32'(guess_valid), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);

      // Enter 1,3,0,2 -> 10_00_11_01
      press(2'd1);
      check("g1_count1", 32'(digit_count), 32'd1);
      check("g1_guess1", 32'(guess_out), 32'h01);
      press(2'd3);
      press(2'd0);
      check("g1_guess3", 32'(guess_out), 32'h0D);
      check("g1_valid3", 32'(guess_valid), 32'd0);
      press(2'd2);
      check("g1_guess4", 32'(guess_out), 32'h8D);
      check("g1_count4", 32'(digit_count), 32'd4);
      check("g1_fill_valid", 32'(guess_valid), 32'(!CONFIRM));
      confirm();
      check("g1_valid", 32'(guess_valid), 32'd1);

      // PRESENT holds for 5 cycles of no ready while keys are pulsed
      for (int i = 0; i < 5; i++) begin
         key_valid = 1'b1; key_sym = 2'd3; key_del = (i == 2); key_enter = 1'b1;
         step();
         idle();
         check("hold_guess", 32'(guess_out), 32'h8D);
         check("hold_valid", 32'(guess_valid), 32'd1);
      end
      check("hold_count", 32'(digit_count), 32'd4);
      accept();
      check("acc_att", 32'(attempts), 32'd1);
      check("acc_count", 32'(digit_count), 32'd0);
      check("acc_valid", 32'(guess_valid), 32'd0);
      check("acc_guess", 32'(guess_out), 32'h00);

      // Backspace: empty no-op, then 2,1,del,3,3,0 -> 00_11_11_10
      del();
      check("del_empty", 32'(digit_count), 32'd0);
      press(2'd2);
      press(2'd1);
      del();
      check("del_count", 32'(digit_count), 32'd1);
      check("del_guess", 32'(guess_out), 32'h02);
      press(2'd3);
      press(2'd3);
      press(2'd0);
      confirm();
      check("g2_guess", 32'(guess_out), 32'h3E);
      check("g2_valid", 32'(guess_valid), 32'd1);
      // ready outside PRESENT would be ignored; here it is accepted
      accept();
      check("g2_att", 32'(attempts), 32'd2);

      // guess_ready while in ENTRY is ignored
      accept();
      check("rdy_entry_att", 32'(attempts), 32'd2);

      // key_valid + key_del together at count 2 -> delete wins
      press(2'd1);
      press(2'd2);
      key_valid = 1'b1; key_sym = 2'd3; key_del = 1'b1;
      step();
      idle();
      check("vd_count", 32'(digit_count), 32'd1);
      check("vd_guess", 32'(guess_out), 32'h01);
      press(2'd0);
      press(2'd0);
      press(2'd0);
      confirm();
      check("vd_valid", 32'(guess_valid), 32'd1);

      // Reset in PRESENT clears everything
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_guess", 32'(guess_out), 32'h00);
      check("mid_rst_count", 32'(digit_count), 32'd0);
      check("mid_rst_att", 32'(attempts), 32'd0);
      check("mid_rst_valid", 32'(guess_valid), 32'd0);

      // Ten accepted guesses -> lockout
      for (int g = 0; g < 10; g++) begin
         for (int k = 0; k < 4; k++) press(2'((g + k) % 4));
         confirm();
         check("lp_valid", 32'(guess_valid), 32'd1);
         accept();
         check("lp_att", 32'(attempts), 32'(g + 1));
         check("lp_locked", 32'(locked), 32'(g == 9));
      end
      press(2'd3);
      del();
      check("lk_count", 32'(digit_count), 32'd0);
      check("lk_guess", 32'(guess_out), 32'h00);
      check("lk_locked", 32'(locked), 32'd1);
      accept();
      check("lk_att_sat", 32'(attempts), 32'd10);
      check("lk_valid", 32'(guess_valid), 32'd0);

      // new_game beats a simultaneous key and returns to ENTRY
      new_game = 1'b1; key_valid = 1'b1; key_sym = 2'd2;
      step();
      idle();
      check("ng_att", 32'(attempts), 32'd0);
      check("ng_locked", 32'(locked), 32'd0);
      check("ng_count", 32'(digit_count), 32'd0);
      press(2'd2);
      check("ng_entry_count", 32'(digit_count), 32'd1);
      check("ng_entry_guess", 32'(guess_out), 32'h02);

`ifdef ENTRY_CONFIRM_EN
      // Confirm build: enter gating on a partial / full buffer
      new_game = 1'b1;
      step();
      idle();
      press(2'd1); press(2'd2); press(2'd3); press(2'd0);
      check("cf_full_valid", 32'(guess_valid), 32'd0);
      press(2'd3);
      check("cf_full_ignore", 32'(guess_out), 32'h39);
      del();
      check("cf_del_count", 32'(digit_count), 32'd3);
      key_enter = 1'b1;
      step();
      key_enter = 1'b0;
      check("cf_partial", 32'(guess_valid), 32'd0);
      press(2'd2);
      key_enter = 1'b1; key_del = 1'b1;
      step();
      idle();
      check("cf_del_wins", 32'(digit_count), 32'd3);
      check("cf_del_valid", 32'(guess_valid), 32'd0);
      press(2'd2);
      key_enter = 1'b1;
      step();
      key_enter = 1'b0;
      check("cf_enter", 32'(guess_valid), 32'd1);
      check("cf_guess", 32'(guess_out), 32'hB9);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/guess_entry_buffer.md
Name: guess_entry_buffer

Overview:
Parametrised successor to the 4-digit Mastermind guess-capture logic. Collects stabilized keystrokes into an N-digit guess register and presents the completed guess to the checker over a valid/ready handshake. Tracks the attempt count, enforces a maximum attempt limit, and supports backspace. Sits between the debounced user-input stage and the guess comparator.

Parameters:
NUM_DIGITS, 4, digits per guess (>=1)
SYM_W, 2, bits per digit; 2**SYM_W symbols (colours)
MAX_ATTEMPTS, 10, guesses allowed before lockout (1..2**ATT_W-1)
ATT_W, 4, width of attempts counter
CNT_W, $clog2(NUM_DIGITS+1), width of digit_count

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
key_valid  in  1  one-cycle pulse: stabilized symbol key pressed
key_sym  in  SYM_W  symbol value, sampled when key_valid=1
key_del  in  1  one-cycle pulse: backspace
key_enter  in  1  one-cycle pulse: submit (used only with ENTRY_CONFIRM_EN)
new_game  in  1  one-cycle pulse: clear guess and attempts
guess_ready  in  1  comparator accepts guess
guess_out  out  NUM_DIGITS*SYM_W  digit i at [i*SYM_W +: SYM_W]; digit 0 = first entered
guess_valid  out  1  completed guess presented
digit_count  out  CNT_W  digits currently entered
attempts  out  ATT_W  guesses accepted by comparator
locked  out  1  attempts == MAX_ATTEMPTS

Behaviour:
- Reset is synchronous, active-high, on CLOCK_50; clock is CLOCK_50. Reset values: guess_out=0, digit_count=0, attempts=0, guess_valid=0, locked=0, state=ENTRY.
- Registered outputs only; no combinational path from inputs to outputs.
- State ENTRY:
  - key_del=1 and digit_count>0: clear digit[digit_count-1] to 0; digit_count-1.
  - key_del=1 and digit_count=0: no-op.
  - key_valid=1 and digit_count<NUM_DIGITS: digit[digit_count]<=key_sym; digit_count+1.
  - key_del and key_valid in the same cycle: key_del wins; the symbol is dropped.
  - key_valid with the buffer full: ignored.
- Submit (macro off): when a key fills the last digit at edge N, state=PRESENT and guess_valid=1 from cycle N+1.
- State PRESENT:
  - guess_valid held high; guess_out stable; key_valid, key_del and key_enter ignored.
  - On a cycle with guess_valid & guess_ready: attempts+1, guess_out=0, digit_count=0, guess_valid=0 after that edge.
  - Next state is LOCKED if the new attempts == MAX_ATTEMPTS, else ENTRY.
- State LOCKED: locked=1; all keys ignored; guess_out holds 0; the only exits are new_game or reset.
- new_game (any state): same effect as reset on the next edge. reset has priority over new_game, and new_game over all other inputs.
- A guess_ready pulse outside PRESENT is ignored.
- attempts never wraps; saturates at MAX_ATTEMPTS.

Optional Feature:
ENTRY_CONFIRM_EN
- Defined: filling the buffer does not submit. A key_enter pulse with digit_count==NUM_DIGITS in ENTRY moves to PRESENT (guess_valid high the next cycle). key_enter with a partial buffer is ignored. key_del still works on a full buffer before enter. If key_del and key_enter arrive together, key_del wins.
- Undefined: key_enter is ignored; auto-submit as described above.

Test Plan:
- Reset, then key_valid with syms 1,3,0,2 (defaults, macro off) -> guess_out=8'b10_00_11_01, digit_count=4, guess_valid=1 the cycle after the 4th key.
- Enter 2,1; key_del; enter 3,3,0 -> guess_out=8'b00_11_11_10; key_del on an empty buffer leaves digit_count=0.
- Hold guess_ready=0 for 5 cycles while in PRESENT, pulsing key_valid -> guess_out unchanged; then guess_ready=1 -> attempts=1, digit_count=0, guess_valid=0.
- Submit 10 guesses with MAX_ATTEMPTS=10 -> locked=1 and attempts=10; further keys ignored; new_game -> attempts=0, locked=0, state ENTRY.
- key_valid and key_del asserted together at digit_count=2 -> digit_count=1, symbol dropped. Reset in the middle of PRESENT -> all outputs 0 on the next cycle.
- With ENTRY_CONFIRM_EN: 4 keys -> guess_valid stays 0; key_enter at digit_count=3 is ignored; key_enter at digit_count=4 -> guess_valid=1 the next cycle.
